// File: rtl/counter_counter_if.sv
// Load/enable/data bundle for counter_counter; the master drives requests, the counter returns q.
// q is a registered output on the slave side.
interface counter_counter_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic             enable;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (
      output load,
      output enable,
      output d,
      input  q
   );

   modport slave (
      input  load,
      input  enable,
      input  d,
      output q
   );
endinterface

// File: rtl/counter_counter.sv
// Modulo-MAX up-counter with parallel load and enable; priority is reset > load > enable > hold.
// One-edge latency from any sampled input to q; no backpressure, the counter accepts inputs every cycle.
module counter_counter #(
   parameter  int MAX   = 12,
   localparam int WIDTH = $clog2(MAX)
) (
   input logic              clk,
   input logic              rst,
   counter_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MAX - 1);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             load_in_range;

   // Extra bit keeps the compare correct when MAX is a power of two.
   assign load_in_range = ({1'b0, bus.d} < MAX_EXT);

   always_comb begin
      count_d = count_q;
      if (bus.load) begin
         count_d = load_in_range ? bus.d : '0;
      end else if (bus.enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.q = count_q;

endmodule

// File: tb/tb_counter_counter.sv
// Directed and randomised checks of counter_counter (MAX=12) with a cycle-level reference model.
module tb_counter_counter;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   model_q;

   counter_counter_if #(.WIDTH(4)) bus ();

   counter_counter #(.MAX(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs at the falling edge, then check q 1ns after the following rising edge.
   task automatic step(input logic r, input logic l, input logic e, input logic [3:0] dv,
                       input logic [3:0] exp, input string tag);
      @(negedge clk);
      rst        = r;
      bus.load   = l;
      bus.enable = e;
      bus.d      = dv;
      @(posedge clk);
      #1;
      checks++;
      assert (bus.q === exp)
      else begin
         errors++;
         $error("FAIL %s: q=%0d expected %0d", tag, bus.q, exp);
      end
   endtask

   task automatic check_range(input string tag);
      checks++;
      assert (bus.q < 4'd12)
      else begin
         errors++;
         $error("FAIL %s: q=%0d expected below 12", tag, bus.q);
      end
   endtask

   initial begin
      logic [3:0] count_exp [16];
      logic       r, l, e;
      logic [3:0] dv;

      errors     = 0;
      checks     = 0;
      rst        = 1'b1;
      bus.load   = 1'b0;
      bus.enable = 1'b0;
      bus.d      = '0;

      // Reset for two edges, then idle.
      step(1, 0, 0, 4'd0, 4'd0, "reset_edge1");
      step(1, 0, 0, 4'd0, 4'd0, "reset_edge2");
      step(0, 0, 0, 4'd0, 4'd0, "idle_after_reset1");
      step(0, 0, 0, 4'd0, 4'd0, "idle_after_reset2");

      // Count through the wrap.
      count_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                    4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 4'd0, count_exp[i], $sformatf("count_%0d", i));
         check_range($sformatf("count_range_%0d", i));
      end

      // Hold at 4.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 4'd9, 4'd4, $sformatf("hold_%0d", i));
      end

      // Load sweep 15..0; 15..12 are out of range and clear to 0.
      step(0, 1, 0, 4'd15, 4'd0, "load_d15");
      step(0, 1, 0, 4'd14, 4'd0, "load_d14");
      step(0, 1, 0, 4'd13, 4'd0, "load_d13");
      step(0, 1, 0, 4'd12, 4'd0, "load_d12");
      for (int v = 11; v >= 0; v--) begin
         step(0, 1, 0, 4'(v), 4'(v), $sformatf("load_d%0d", v));
      end

      // Load beats enable.
      step(0, 1, 1, 4'd7, 4'd7, "load_over_enable_7");
      step(0, 1, 1, 4'd11, 4'd11, "load_over_enable_11");
      step(0, 1, 1, 4'd13, 4'd0, "load_oor_over_enable");
      step(0, 1, 0, 4'd11, 4'd11, "load_11_before_wrap");
      step(0, 0, 1, 4'd0, 4'd0, "wrap_from_loaded_11");

      // Reset beats load and enable, then hold until enabled.
      step(0, 1, 0, 4'd8, 4'd8, "preload_8");
      step(1, 1, 1, 4'd5, 4'd0, "reset_over_load_enable");
      step(0, 0, 0, 4'd5, 4'd0, "hold_after_reset1");
      step(0, 0, 0, 4'd5, 4'd0, "hold_after_reset2");
      step(0, 0, 1, 4'd5, 4'd1, "count_after_reset");

      // Randomised run against an independent model.
      model_q = 1;
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 19) == 0);
         l  = ($urandom_range(0, 3) == 0);
         e  = ($urandom_range(0, 3) != 0);
         dv = 4'($urandom_range(0, 15));
         if (r) begin
            model_q = 0;
         end else if (l) begin
            model_q = (int'(dv) > 11) ? 0 : int'(dv);
         end else if (e) begin
            model_q = (model_q + 1) % 12;
         end
         step(r, l, e, dv, 4'(model_q), $sformatf("random_%0d", i));
         check_range($sformatf("random_range_%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
